// File: rtl/fetch_stage.sv
// fetch_stage: PC register, ROM address generation and IF/ID pipeline register.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   stall               decode hazard; holds PC and IF/ID
//   redirect, redirect_pc  taken control transfer from execute (low two bits ignored)
//   rom_addr, rom_instr word address to / instruction from the combinational ROM
//   if_pc, if_instr, if_valid  IF/ID register contents
//   halted              halt word 32'hFFFF_FFFF fetched, fetch frozen
// Macro FETCH_HALT_DETECT_EN enables the RUN/HALT state machine; when it is
// undefined the halt word is fetched as an ordinary instruction.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [4:0]  rom_addr,
    input  logic [31:0] rom_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        halted
);
    logic [31:0] pc;
    assign rom_addr = pc[6:2];
`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state    <= RUN;
`endif
        end else if (redirect) begin
            // Redirect beats stall and squashes a speculatively fetched halt.
            pc       <= redirect_pc & ~32'd3;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state    <= RUN;
`endif
        end else if (!stall
`ifdef FETCH_HALT_DETECT_EN
                     && state == RUN
`endif
                    ) begin
            if_pc    <= pc;
            if_instr <= rom_instr;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
`ifdef FETCH_HALT_DETECT_EN
            // The halt word itself is passed downstream once as valid.
            if (rom_instr == 32'hFFFF_FFFF)
                state <= HALT;
`endif
        end
`ifdef FETCH_HALT_DETECT_EN
        else if (!stall) begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard-checked bench for fetch_stage (default and halt-detect builds).
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam bit HALT_EN =
`ifdef FETCH_HALT_DETECT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [4:0]  rom_addr;
    logic [31:0] rom_instr, if_pc, if_instr;
    logic        if_valid, halted;

    logic        rst2;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic [4:0]  rom_addr2;
    logic [31:0] rom_instr2, if_pc2, if_instr2;
    logic        if_valid2, halted2;

    logic [31:0] rom [32];
    assign rom_instr  = rom[rom_addr];
    assign rom_instr2 = rom[rom_addr2];

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_instr(rom_instr),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'h0000_007C)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(zero), .redirect(zero),
        .redirect_pc(zero32), .rom_addr(rom_addr2), .rom_instr(rom_instr2),
        .if_pc(if_pc2), .if_instr(if_instr2), .if_valid(if_valid2), .halted(halted2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [4:0]  addr;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] m_pc;
    logic        m_halt;

    task automatic model_reset(input logic [31:0] rpc);
        m_pc   = rpc;
        m_halt = 1'b0;
        cur    = '{pc: 32'h0, instr: NOP, valid: 1'b0, halted: 1'b0, addr: rpc[6:2]};
    endtask

    // Drive one cycle, predict IF/ID after the edge, compare once it is visible.
    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        exp_t e;
        stall = s; redirect = r; redirect_pc = rp;
        e = cur;
        if (r) begin
            m_pc = {rp[31:2], 2'b00};
            m_halt = 1'b0;
            e.instr = NOP; e.valid = 1'b0; e.halted = 1'b0;
        end else if (!s) begin
            if (m_halt) begin
                e.instr = NOP; e.valid = 1'b0;
            end else begin
                e.pc = m_pc; e.instr = rom[m_pc[6:2]]; e.valid = 1'b1;
                if (HALT_EN && e.instr == 32'hFFFF_FFFF) begin
                    m_halt = 1'b1; e.halted = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
        e.addr = m_pc[6:2];
        cur = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
        check("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
        check("halted", {31'h0, halted}, {31'h0, e.halted});
        check("rom_addr", {27'h0, rom_addr}, {27'h0, e.addr});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[0] = 32'h0060_0513;
        rom[1] = 32'h00C0_00EF;
        rom[5] = 32'hFFFF_FFFF;
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #12;
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_rom_addr", {27'h0, rom_addr}, 32'h0);
        check("wrap_rst_addr", {27'h0, rom_addr2}, 32'd31);
        rst = 1'b0; rst2 = 1'b0;
        model_reset(32'h0);

        step(0, 0, 0);
        check("first_instr", if_instr, 32'h0060_0513);
        check("wrap_pc0", if_pc2, 32'h0000_007C);
        check("wrap_addr0", {27'h0, rom_addr2}, 32'd0);
        step(0, 0, 0);
        check("second_instr", if_instr, 32'h00C0_00EF);
        check("wrap_pc1", if_pc2, 32'h0000_0080);
        check("wrap_instr1", if_instr2, 32'h0060_0513);

        step(1, 0, 0);
        check("stall_if_pc", if_pc, 32'h4);
        check("stall_rom_addr", {27'h0, rom_addr}, 32'd2);
        step(1, 0, 0);
        step(0, 0, 0);
        check("release_if_pc", if_pc, 32'h8);

        step(1, 1, 32'h0000_001B);
        check("redir_addr", {27'h0, rom_addr}, 32'd6);
        check("redir_valid", {31'h0, if_valid}, 32'h0);
        step(0, 0, 0);
        check("redir_if_pc", if_pc, 32'h18);

        step(0, 1, 32'h10);
        step(0, 0, 0);
        step(0, 0, 0);
        check("halt_word", if_instr, 32'hFFFF_FFFF);
        check("halt_word_valid", {31'h0, if_valid}, 32'h1);
        check("halted_flag", {31'h0, halted}, {31'h0, HALT_EN});
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("halt_freeze_addr", {27'h0, rom_addr}, HALT_EN ? 32'd6 : 32'd9);
        step(0, 1, 32'h10);
        check("unhalt_addr", {27'h0, rom_addr}, 32'd4);
        step(0, 0, 0);

        step(0, 1, 32'h10);
        step(0, 0, 0);
        step(0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_if_pc", if_pc, 32'h0);
        check("async_if_instr", if_instr, NOP);
        check("async_if_valid", {31'h0, if_valid}, 32'h0);
        check("async_halted", {31'h0, halted}, 32'h0);
        check("async_rom_addr", {27'h0, rom_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(32'h0);
        step(0, 0, 0);
        check("refetch_instr", if_instr, 32'h0060_0513);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
